// File: rtl/dm_cache_pkg.sv
// Shared definitions for the direct-mapped cache controller: request
// opcodes, controller states and an address-field extraction helper.
package dm_cache_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_WRMEM  = 2'd3
    } state_t;

    // Extract a w-bit field starting at bit lsb from an address (up to 32 bits).
    function automatic logic [31:0] addr_field(input logic [31:0] a,
                                               input int unsigned lsb,
                                               input int unsigned w);
        return (a >> lsb) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Bus bundle between the processor/memory side (master) and the cache
// controller (slave): request/response handshake plus main-memory port.
interface dm_cache_ctrl_if #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 13,
    parameter int WORDS  = 3
);
    logic                     req_valid;
    logic                     req_ready;
    logic [1:0]               op;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        wdata;
    logic                     rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_hit;
    logic                     rsp_err;
    logic                     mem_req_valid;
    logic                     mem_req_we;
    logic [ADDR_W-1:0]        mem_req_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_ack;
    logic [WORDS*DATA_W-1:0]  mem_rdata;

    modport master (
        output req_valid, op, addr, wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err,
               mem_req_valid, mem_req_we, mem_req_addr, mem_wdata
    );

    modport slave (
        input  req_valid, op, addr, wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err,
               mem_req_valid, mem_req_we, mem_req_addr, mem_wdata
    );
endinterface

// File: rtl/dm_cache_array.sv
// Tag/valid/data storage for the direct-mapped cache. One combinational
// read port, one write port with per-word data mask. Only valid bits are
// reset; tag and data contents are don't-care until their line is valid.
module dm_cache_array #(
    parameter int DATA_W  = 13,
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 8,
    parameter int WORDS   = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [INDEX_W-1:0]      rd_idx_i,
    output logic                    rd_valid_o,
    output logic [TAG_W-1:0]        rd_tag_o,
    output logic [WORDS*DATA_W-1:0] rd_data_o,
    input  logic                    we_i,
    input  logic [INDEX_W-1:0]      wr_idx_i,
    input  logic [TAG_W-1:0]        wr_tag_i,
    input  logic                    wr_valid_i,
    input  logic [WORDS-1:0]        wr_mask_i,
    input  logic [WORDS*DATA_W-1:0] wr_data_i
);
    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [WORDS*DATA_W-1:0] data_q [LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    // Valid bits: cleared asynchronously on reset, otherwise set/cleared by the write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    // Tag and masked data words are written with the line; no reset needed.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            for (int w = 0; w < WORDS; w++) begin
                if (wr_mask_i[w]) begin
                    data_q[wr_idx_i][w*DATA_W +: DATA_W] <= wr_data_i[w*DATA_W +: DATA_W];
                end
            end
        end
    end
endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller.
// Handles READ/WRITE/INVALIDATE over a valid/ready handshake, fills whole
// blocks from main memory on read misses and keeps saturating hit/miss counts.
import dm_cache_pkg::*;

module dm_cache_ctrl #(
    parameter int DATA_W   = 13,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2,
    parameter int WORDS    = 3,
    parameter int TAG_W    = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    dm_cache_ctrl_if.slave   bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam logic [OFFSET_W:0] WORDS_L = (OFFSET_W+1)'(WORDS);

    state_t                  state_q;
    logic [1:0]              op_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    hit_q;

    logic                    rsp_valid_q, rsp_hit_q, rsp_err_q;
    logic [DATA_W-1:0]       rsp_data_q;
    logic                    mem_req_valid_q, mem_req_we_q;
    logic [ADDR_W-1:0]       mem_req_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;
    logic [CNT_W-1:0]        hit_cnt_q, miss_cnt_q;

    logic [TAG_W-1:0]        tag_f;
    logic [INDEX_W-1:0]      idx_f;
    logic [OFFSET_W-1:0]     off_f;
    logic                    off_err;
    logic                    hit;

    logic                    rd_valid;
    logic [TAG_W-1:0]        rd_tag;
    logic [WORDS*DATA_W-1:0] rd_data;
    logic [DATA_W-1:0]       look_word, fill_word;
    logic [WORDS-1:0]        off_mask;

    logic                    arr_we, arr_wvalid;
    logic [WORDS-1:0]        arr_wmask;
    logic [WORDS*DATA_W-1:0] arr_wdata;

    logic                    accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign tag_f   = TAG_W'(addr_field(32'(addr_q), OFFSET_W + INDEX_W, TAG_W));
    assign idx_f   = INDEX_W'(addr_field(32'(addr_q), OFFSET_W, INDEX_W));
    assign off_f   = OFFSET_W'(addr_field(32'(addr_q), 0, OFFSET_W));
    assign off_err = {1'b0, off_f} >= WORDS_L;
    assign hit     = rd_valid && (rd_tag == tag_f);
    assign accept  = (state_q == ST_IDLE) && bus.req_valid && (bus.op != OP_NOP);

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_hit       = rsp_hit_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_we    = mem_req_we_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign hit_count         = hit_cnt_q;
    assign miss_count        = miss_cnt_q;

    dm_cache_array #(
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .WORDS   (WORDS)
    ) u_array (
        .clk_i      (clk),
        .rst_i      (reset),
        .rd_idx_i   (idx_f),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (arr_we),
        .wr_idx_i   (idx_f),
        .wr_tag_i   (tag_f),
        .wr_valid_i (arr_wvalid),
        .wr_mask_i  (arr_wmask),
        .wr_data_i  (arr_wdata)
    );

    // Pick the addressed word out of the stored line and the incoming fill block.
    always_comb begin
        look_word = '0;
        fill_word = '0;
        off_mask  = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (off_f == OFFSET_W'(w)) begin
                look_word   = rd_data[w*DATA_W +: DATA_W];
                fill_word   = bus.mem_rdata[w*DATA_W +: DATA_W];
                off_mask[w] = 1'b1;
            end
        end
    end

    // Array write port: write-hit word update, invalidate, or full-line fill.
    always_comb begin
        arr_we     = 1'b0;
        arr_wvalid = 1'b0;
        arr_wmask  = '0;
        arr_wdata  = '0;
        case (state_q)
            ST_LOOKUP: begin
                if (!off_err && hit && op_q == OP_WRITE) begin
                    arr_we     = 1'b1;
                    arr_wvalid = 1'b1;
                    arr_wmask  = off_mask;
                    arr_wdata  = {WORDS{wdata_q}};
                end else if (!off_err && hit && op_q == OP_INV) begin
                    arr_we     = 1'b1;
                    arr_wvalid = 1'b0;
                end
            end
            ST_FILL: begin
                if (bus.mem_ack) begin
                    arr_we     = 1'b1;
                    arr_wvalid = 1'b1;
                    arr_wmask  = '1;
                    arr_wdata  = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Capture the accepted request; these hold only while it is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= bus.op;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
        if (state_q == ST_LOOKUP) begin
            hit_q <= hit;
        end
    end

    // Controller FSM with registered response, memory-request and counter outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rsp_valid_q     <= 1'b0;
            rsp_hit_q       <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_data_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_wdata_q     <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (off_err) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (op_q == OP_READ) begin
                        if (hit) begin
                            rsp_valid_q <= 1'b1;
                            rsp_hit_q   <= 1'b1;
                            rsp_data_q  <= look_word;
                            hit_cnt_q   <= sat_inc(hit_cnt_q);
                            state_q     <= ST_IDLE;
                        end else begin
                            miss_cnt_q      <= sat_inc(miss_cnt_q);
                            mem_req_valid_q <= 1'b1;
                            mem_req_we_q    <= 1'b0;
                            mem_req_addr_q  <= {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                            mem_wdata_q     <= '0;
                            state_q         <= ST_FILL;
                        end
                    end else if (op_q == OP_WRITE) begin
                        if (hit) begin
                            hit_cnt_q <= sat_inc(hit_cnt_q);
                        end else begin
                            miss_cnt_q <= sat_inc(miss_cnt_q);
                        end
                        mem_req_valid_q <= 1'b1;
                        mem_req_we_q    <= 1'b1;
                        mem_req_addr_q  <= addr_q;
                        mem_wdata_q     <= wdata_q;
                        state_q         <= ST_WRMEM;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= hit;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (bus.mem_ack) begin
                        mem_req_valid_q <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        rsp_data_q      <= fill_word;
                        state_q         <= ST_IDLE;
                    end
                end
                ST_WRMEM: begin
                    if (bus.mem_ack) begin
                        mem_req_valid_q <= 1'b0;
                        mem_req_we_q    <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        rsp_hit_q       <= hit_q;
                        state_q         <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: read miss/fill, read hit latency,
// write-through, offset error, invalidate, NOP and reset during a fill.
module tb_dm_cache_ctrl;
    import dm_cache_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    int          checks;
    int          failures;

    dm_cache_ctrl_if #(.DATA_W(13), .ADDR_W(13), .WORDS(3)) bus ();

    dm_cache_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns 1 ns after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [12:0] addr, input logic [12:0] wd);
        @(negedge clk);
        chk("req_ready_before_send", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.op        = op;
        bus.addr      = addr;
        bus.wdata     = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.op        = OP_NOP;
    endtask

    // One-cycle memory acknowledge; returns 1 ns after the edge that sees it.
    task automatic ack(input logic [38:0] blk);
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = blk;
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [38:0] BLK = {13'h0CCC, 13'h0BBB, 13'h0AAA};

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.op        = OP_NOP;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_hit_count", 64'(hit_count), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Read miss: tag 0x12, idx 3, off 1 -> addr 0x24D, fill addr 0x24C.
        send(OP_READ, 13'h24D, 13'h0);
        chk("lookup_req_ready", 64'(bus.req_ready), 64'd0);
        step();
        chk("miss_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("miss_mem_req_we", 64'(bus.mem_req_we), 64'd0);
        chk("miss_mem_req_addr", 64'(bus.mem_req_addr), 64'h24C);
        chk("miss_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("miss_count_1", 64'(miss_count), 64'd1);
        step();
        chk("fill_hold_req", 64'(bus.mem_req_valid), 64'd1);
        chk("fill_req_ready", 64'(bus.req_ready), 64'd0);
        ack(BLK);
        chk("fill_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("fill_rsp_data", 64'(bus.rsp_data), 64'h0BBB);
        chk("fill_rsp_hit", 64'(bus.rsp_hit), 64'd0);
        chk("fill_mem_req_drop", 64'(bus.mem_req_valid), 64'd0);
        chk("fill_rsp_req_ready", 64'(bus.req_ready), 64'd1);

        // Read hit, response on the 2nd cycle after acceptance.
        send(OP_READ, 13'h24D, 13'h0);
        chk("hit_rsp_not_early", 64'(bus.rsp_valid), 64'd0);
        step();
        chk("hit_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("hit_rsp_data", 64'(bus.rsp_data), 64'h0BBB);
        chk("hit_rsp_hit", 64'(bus.rsp_hit), 64'd1);
        chk("hit_no_mem_req", 64'(bus.mem_req_valid), 64'd0);
        chk("hit_count_1", 64'(hit_count), 64'd1);

        // Write hit off 2 -> write-through, then read it back from the cache.
        send(OP_WRITE, 13'h24E, 13'h1234);
        step();
        chk("wr_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("wr_mem_req_we", 64'(bus.mem_req_we), 64'd1);
        chk("wr_mem_req_addr", 64'(bus.mem_req_addr), 64'h24E);
        chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'h1234);
        chk("wr_no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
        chk("wr_hit_count", 64'(hit_count), 64'd2);
        ack('0);
        chk("wr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("wr_rsp_hit", 64'(bus.rsp_hit), 64'd1);
        chk("wr_rsp_data_zero", 64'(bus.rsp_data), 64'd0);
        chk("wr_mem_req_drop", 64'(bus.mem_req_valid), 64'd0);
        send(OP_READ, 13'h24E, 13'h0);
        step();
        chk("rdback_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rdback_rsp_data", 64'(bus.rsp_data), 64'h1234);
        chk("rdback_no_mem", 64'(bus.mem_req_valid), 64'd0);
        chk("rdback_hit_count", 64'(hit_count), 64'd3);

        // Offset 3 with 3 words per block -> error, nothing else changes.
        send(OP_READ, 13'h24F, 13'h0);
        step();
        chk("err_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("err_rsp_err", 64'(bus.rsp_err), 64'd1);
        chk("err_rsp_hit", 64'(bus.rsp_hit), 64'd0);
        chk("err_no_mem", 64'(bus.mem_req_valid), 64'd0);
        chk("err_hit_count", 64'(hit_count), 64'd3);
        chk("err_miss_count", 64'(miss_count), 64'd1);

        // NOP is swallowed: no response, stays ready.
        send(OP_NOP, 13'h24D, 13'h0);
        chk("nop_req_ready", 64'(bus.req_ready), 64'd1);
        step();
        chk("nop_no_rsp", 64'(bus.rsp_valid), 64'd0);

        // Invalidate with wrong tag 0x13 keeps the line.
        send(OP_INV, 13'h26C, 13'h0);
        step();
        chk("inv_wrong_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("inv_wrong_rsp_hit", 64'(bus.rsp_hit), 64'd0);
        send(OP_READ, 13'h24D, 13'h0);
        step();
        chk("inv_kept_hit", 64'(bus.rsp_hit), 64'd1);
        chk("inv_kept_data", 64'(bus.rsp_data), 64'h0BBB);
        chk("inv_kept_hit_count", 64'(hit_count), 64'd4);

        // Invalidate with matching tag, then the same read misses.
        send(OP_INV, 13'h24C, 13'h0);
        step();
        chk("inv_rsp_hit", 64'(bus.rsp_hit), 64'd1);
        chk("inv_counters_hit", 64'(hit_count), 64'd4);
        send(OP_READ, 13'h24D, 13'h0);
        step();
        chk("after_inv_miss_req", 64'(bus.mem_req_valid), 64'd1);
        chk("after_inv_miss_count", 64'(miss_count), 64'd2);
        ack(BLK);
        chk("after_inv_fill_data", 64'(bus.rsp_data), 64'h0BBB);

        // Reset while filling idx 1; late ack ignored; idx 3 line lost.
        send(OP_READ, 13'h0A4, 13'h0);
        step();
        chk("rstfill_mem_req", 64'(bus.mem_req_valid), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstfill_mem_req_drop", 64'(bus.mem_req_valid), 64'd0);
        chk("rstfill_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rstfill_hit_count", 64'(hit_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ack(BLK);
        chk("late_ack_no_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("late_ack_no_mem", 64'(bus.mem_req_valid), 64'd0);
        chk("late_ack_ready", 64'(bus.req_ready), 64'd1);
        send(OP_READ, 13'h24D, 13'h0);
        step();
        chk("post_rst_miss_req", 64'(bus.mem_req_valid), 64'd1);
        chk("post_rst_no_hit_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("post_rst_miss_count", 64'(miss_count), 64'd1);
        ack(BLK);
        chk("post_rst_fill_data", 64'(bus.rsp_data), 64'h0BBB);
        chk("post_rst_fill_hit", 64'(bus.rsp_hit), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
